// File: rtl/dram_block_responder_pkg.sv
// Shared types and geometry for the block responder: block layout, FSM states,
// port ids and the address-to-block-index mapping.
package dram_block_responder_pkg;
    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 4;
    localparam int NUM_BLOCKS  = 256;
    localparam int OFF         = $clog2(BLOCK_WORDS * WORD_W / 8);
    localparam int IDX         = $clog2(NUM_BLOCKS);

    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] block_t;
    typedef logic [ADDR_W-1:0]                  addr_t;
    typedef logic [IDX-1:0]                     idx_t;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} resp_state_e;
    typedef enum logic {PORT1, PORT2} port_id_e;

    // Offset bits and bits above the store depth are dropped: accesses are block-aligned and wrap.
    function automatic idx_t blk_idx(input addr_t a);
        return a[OFF+IDX-1:OFF];
    endfunction
endpackage

// File: rtl/dram_block_responder_if.sv
// Cache-to-memory block bus: read-only instruction port 1, read/write data port 2.
interface dram_block_responder_if;
    import dram_block_responder_pkg::*;

    logic   p1_request;
    addr_t  p1_address;
    block_t p1_read_data;
    logic   p1_acknowledge;

    logic   p2_request;
    logic   p2_we;
    addr_t  p2_address;
    block_t p2_write_data;
    block_t p2_read_data;
    logic   p2_acknowledge;

    logic   busy;

    modport master (
        output p1_request, p1_address,
        output p2_request, p2_we, p2_address, p2_write_data,
        input  p1_read_data, p1_acknowledge, p2_read_data, p2_acknowledge, busy
    );

    modport slave (
        input  p1_request, p1_address,
        input  p2_request, p2_we, p2_address, p2_write_data,
        output p1_read_data, p1_acknowledge, p2_read_data, p2_acknowledge, busy
    );
endinterface

// File: rtl/dram_block_responder_arbiter.sv
// Two-port round-robin arbiter; the last-grant register only advances when the
// responder actually accepts a request.
module mem_rr_arbiter
    import dram_block_responder_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_req_p1,
    input  logic       i_req_p2,
    input  logic       i_accept,
    output logic [1:0] o_grant
);
    port_id_e r_last;

    // bit 0 = port 1, bit 1 = port 2
    always_comb begin
        o_grant = 2'b00;
        if (i_req_p1 && i_req_p2)
            o_grant = (r_last == PORT1) ? 2'b10 : 2'b01;
        else if (i_req_p1)
            o_grant = 2'b01;
        else if (i_req_p2)
            o_grant = 2'b10;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset)
            r_last <= PORT1;
        else if (i_accept && (o_grant != 2'b00))
            r_last <= o_grant[1] ? PORT2 : PORT1;
    end
endmodule

// File: rtl/dram_block_responder.sv
// Memory-side block responder: arbitrates both cache ports, serves one access at a
// time after a fixed latency and pulses the granted port's acknowledge for one cycle.
module dram_block_responder
    import dram_block_responder_pkg::*;
#(
    parameter int LATENCY = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    dram_block_responder_if.slave bus
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    resp_state_e      r_state, w_next;
    logic [CNT_W-1:0] r_count;
    port_id_e         r_port;
    idx_t             r_idx;
    logic             r_we;
    block_t           r_wdata;
    block_t           r_p1_rdata, r_p2_rdata;
    block_t           r_mem [NUM_BLOCKS];

    logic [1:0] w_grant;
    logic       w_accept;
    logic       w_done;
    logic       w_unused;

    assign w_unused = ^{bus.p1_address, bus.p2_address};

    mem_rr_arbiter u_arb (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_req_p1 (bus.p1_request),
        .i_req_p2 (bus.p2_request),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.p1_request || bus.p2_request) begin
                    w_accept = 1'b1;
                    w_next   = ACCESS;
                end
            end
            ACCESS: begin
                if (r_count == '0) begin
                    w_done = 1'b1;
                    w_next = ACK;
                end
            end
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request fields are captured at grant; the requester may change them freely afterwards.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_port  <= PORT1;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_count <= CNT_W'(LATENCY - 1);
                r_port  <= w_grant[1] ? PORT2 : PORT1;
                r_idx   <= w_grant[0] ? blk_idx(bus.p1_address) : blk_idx(bus.p2_address);
                r_we    <= w_grant[1] & bus.p2_we;
                r_wdata <= bus.p2_write_data;
            end else if ((r_state == ACCESS) && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Read data is loaded on the edge into ACK and then held until that port's next ack.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_p1_rdata <= '0;
            r_p2_rdata <= '0;
        end else if (w_done) begin
            if (r_port == PORT1)
                r_p1_rdata <= r_mem[r_idx];
            else if (r_we)
                r_p2_rdata <= r_wdata;
            else
                r_p2_rdata <= r_mem[r_idx];
        end
    end

    // Store is never cleared; a reset edge suppresses the commit of an in-flight write.
    always_ff @(posedge i_clock) begin
        if (i_reset && w_done && r_we)
            r_mem[r_idx] <= r_wdata;
    end

    assign bus.p1_read_data   = r_p1_rdata;
    assign bus.p2_read_data   = r_p2_rdata;
    assign bus.p1_acknowledge = (r_state == ACK) && (r_port == PORT1);
    assign bus.p2_acknowledge = (r_state == ACK) && (r_port == PORT2);
    assign bus.busy           = (r_state != IDLE);
endmodule

// File: tb/tb_dram_block_responder.sv
// Bench for dram_block_responder: table of single transfers plus hand-built
// sequences for ties, reset abort and a request dropped mid-access.
module tb_dram_block_responder;
    import dram_block_responder_pkg::*;

    localparam int LAT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dram_block_responder_if bus();

    dram_block_responder #(.LATENCY(LAT)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    block_t sb1[$];
    block_t sb2[$];

    typedef struct {
        bit     p2;
        bit     we;
        addr_t  addr;
        block_t wd;
        block_t exp;
    } vec_t;
    vec_t tbl[9];

    localparam block_t B1 = {32'd1, 32'd2, 32'd3, 32'd4};
    localparam block_t BA = {32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004};
    localparam block_t BB = {32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003, 32'hBBBB_0004};
    localparam block_t BC = {32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004};
    localparam block_t D1 = {32'hD1D1_0001, 32'hD1D1_0002, 32'hD1D1_0003, 32'hD1D1_0004};
    localparam block_t D2 = {32'hD2D2_0001, 32'hD2D2_0002, 32'hD2D2_0003, 32'hD2D2_0004};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic xfer(input bit p2, input bit we, input addr_t a, input block_t wd, input block_t exp);
        bit got;
        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);
        if (p2) begin
            bus.p2_request = 1'b1; bus.p2_we = we; bus.p2_address = a; bus.p2_write_data = wd;
            sb2.push_back(exp);
        end else begin
            bus.p1_request = 1'b1; bus.p1_address = a;
            sb1.push_back(exp);
        end
        got = 1'b0;
        for (int t = 1; t <= 40 && !got; t++) begin
            @(negedge clk);
            if (bus.p1_acknowledge || bus.p2_acknowledge) begin
                got = 1'b1;
                chk("latency", t, LAT + 1);
                chk("ack_port", {bus.p1_acknowledge, bus.p2_acknowledge}, p2 ? 2'b01 : 2'b10);
                chk("busy_ack", bus.busy, 1'b1);
                if (p2) begin
                    chk("p2_data", bus.p2_read_data, sb2.pop_front());
                    bus.p2_request = 1'b0;
                end else begin
                    chk("p1_data", bus.p1_read_data, sb1.pop_front());
                    bus.p1_request = 1'b0;
                end
            end else begin
                chk("busy_access", bus.busy, 1'b1);
            end
        end
        if (!got) begin
            chk("ack_timeout", 1'b0, 1'b1);
            bus.p1_request = 1'b0;
            bus.p2_request = 1'b0;
        end
        @(negedge clk);
        chk("ack_pulse", {bus.p1_acknowledge, bus.p2_acknowledge}, 2'b00);
        chk("busy_after", bus.busy, 1'b0);
    endtask

    // Both ports request together: p2 writes d, p1 reads the same block and sees d.
    task automatic tie(input block_t d);
        int t1, t2;
        @(negedge clk);
        bus.p1_request = 1'b1; bus.p1_address = 32'h40;
        bus.p2_request = 1'b1; bus.p2_we = 1'b1; bus.p2_address = 32'h40; bus.p2_write_data = d;
        sb1.push_back(d);
        sb2.push_back(d);
        t1 = 0; t2 = 0;
        for (int t = 1; t <= 60 && (t1 == 0 || t2 == 0); t++) begin
            @(negedge clk);
            if (bus.p2_acknowledge) begin
                t2 = t;
                chk("tie_p2_data", bus.p2_read_data, sb2.pop_front());
                bus.p2_request = 1'b0;
            end
            if (bus.p1_acknowledge) begin
                t1 = t;
                chk("tie_p1_data", bus.p1_read_data, sb1.pop_front());
                bus.p1_request = 1'b0;
            end
        end
        bus.p1_request = 1'b0;
        bus.p2_request = 1'b0;
        chk("tie_p2_first", t2, LAT + 1);
        chk("tie_p1_second", t1, 2 * LAT + 3);
        @(negedge clk);
        chk("p2_hold", bus.p2_read_data, d);
    endtask

    initial begin
        int n1, t1, t2, na;
        rst = 1'b0;
        bus.p1_request = 1'b0; bus.p1_address = '0;
        bus.p2_request = 1'b0; bus.p2_we = 1'b0; bus.p2_address = '0; bus.p2_write_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_acks", {bus.p1_acknowledge, bus.p2_acknowledge}, 2'b00);
        chk("rst_p1_data", bus.p1_read_data, '0);
        chk("rst_p2_data", bus.p2_read_data, '0);
        rst = 1'b1;

        tbl[0] = '{1'b1, 1'b1, 32'h0000_0040, B1, B1};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0040, '0, B1};
        tbl[2] = '{1'b0, 1'b0, 32'h0000_1040, '0, B1};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_004C, '0, B1};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_0080, BA, BA};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_0080, '0, BA};
        tbl[6] = '{1'b1, 1'b1, 32'h0000_FFF0, BC, BC};
        tbl[7] = '{1'b0, 1'b0, 32'h0000_0FF0, '0, BC};
        tbl[8] = '{1'b0, 1'b0, 32'h1234_5040, '0, B1};
        for (int i = 0; i < 9; i++)
            xfer(tbl[i].p2, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp);

        // Reset during the access phase of a write must abort it silently.
        @(negedge clk);
        bus.p2_request = 1'b1; bus.p2_we = 1'b1; bus.p2_address = 32'h80; bus.p2_write_data = BB;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", bus.busy, 1'b1);
        rst = 1'b0;
        bus.p2_request = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_ack", {bus.p1_acknowledge, bus.p2_acknowledge}, 2'b00);
        rst = 1'b1;
        na = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.p1_acknowledge || bus.p2_acknowledge) na++;
        end
        chk("abort_no_ack", na, 0);
        xfer(1'b0, 1'b0, 32'h80, '0, BA);

        // Fresh reset so the first tie is decided by the reset value of last grant.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tie(D1);
        tie(D2);

        // p1 granted alone, p2 queues behind it, p1 drops its request mid-access.
        @(negedge clk);
        bus.p1_request = 1'b1; bus.p1_address = 32'h40;
        sb1.push_back(D2);
        sb2.push_back(D2);
        n1 = 0; t1 = 0; t2 = 0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (t == 1) begin
                bus.p2_request = 1'b1; bus.p2_we = 1'b0; bus.p2_address = 32'h40;
            end
            if (t == 3) bus.p1_request = 1'b0;
            if (bus.p1_acknowledge) begin
                n1++;
                t1 = t;
                chk("drop_p1_data", bus.p1_read_data, sb1.pop_front());
            end
            if (bus.p2_acknowledge && t2 == 0) begin
                t2 = t;
                chk("drop_p2_data", bus.p2_read_data, sb2.pop_front());
                bus.p2_request = 1'b0;
            end
        end
        bus.p2_request = 1'b0;
        chk("drop_p1_acks", n1, 1);
        chk("drop_p1_time", t1, LAT + 1);
        chk("drop_p2_time", t2, 2 * LAT + 3);
        chk("drop_idle", bus.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
